// File: rtl/mem_io_pkg.sv
// Shared constants for the memory-side responder: bus widths and I/O window decode.
package mem_io_pkg;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 32;

  localparam logic [1:0] IO_BASE_SEL  = 2'b11;
  localparam logic [2:0] IO_UART_ADDR = 3'h0;
  localparam logic [2:0] IO_CLK_ADDR  = 3'h4;
endpackage

// File: rtl/byte_fifo.sv
// First-word-fall-through byte FIFO; a push on a full FIFO lands only alongside a pop.
module byte_fifo
  import mem_io_pkg::*;
#(
  parameter int unsigned DEPTH_BITS = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  push,
  input  logic [DATA_W-1:0]     push_data,
  input  logic                  pop,
  output logic [DATA_W-1:0]     pop_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_BITS:0]   count
);
  localparam int unsigned DEPTH = 1 << DEPTH_BITS;
  localparam int unsigned CW    = DEPTH_BITS + 1;

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr;
  logic [DEPTH_BITS-1:0] rd_ptr;
  logic [DEPTH_BITS:0]   count_q;
  logic                  do_push;
  logic                  do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign count    = count_q;
  assign pop_data = mem[rd_ptr];
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is not reset; only the pointers define contents.
  always_ff @(posedge clk_in) begin
    if (do_push && !rst_in) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/mem_io_responder.sv
// CPU byte-bus responder: RAM with 1-cycle reads plus an I/O window holding
// the UART byte port (TX/RX FIFOs), a cycle counter and the program-stop port.
module mem_io_responder
  import mem_io_pkg::*;
#(
  parameter int unsigned RAM_ADDR_BITS = 17,
  parameter int unsigned TX_DEPTH_BITS = 4,
  parameter int unsigned RX_DEPTH_BITS = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic [ADDR_W-1:0] mem_a,
  input  logic [DATA_W-1:0] mem_dout,
  input  logic              mem_wr,
  output logic [DATA_W-1:0] mem_din,
  output logic              io_buffer_full,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              program_done
);
  localparam int unsigned RAM_WORDS = 1 << RAM_ADDR_BITS;
  localparam int unsigned TX_DEPTH  = 1 << TX_DEPTH_BITS;
  localparam int unsigned TX_CW     = TX_DEPTH_BITS + 1;

  logic [DATA_W-1:0]        ram [RAM_WORDS];
  logic [RAM_ADDR_BITS-1:0] ram_addr;
  logic                     is_io;
  logic [2:0]               io_sel;
  logic                     bus_wr, bus_rd, ram_we;
  logic                     uart_wr, stop_wr, tx_push, tx_pop, tx_empty, tx_full;
  logic [DATA_W-1:0]        tx_push_data;
  logic [TX_DEPTH_BITS:0]   tx_count;
  logic                     rx_push, rx_pop, rx_empty, rx_full;
  logic [DATA_W-1:0]        rx_head;
  logic [RX_DEPTH_BITS:0]   rx_count;
  logic [CNT_W-1:0]         cycle_cnt, snapshot;
  logic [DATA_W-1:0]        ram_rd_q, io_rd_q, io_rd_data;
  logic                     sel_ram_q;
  logic                     unused_bits;

  assign unused_bits = &{1'b0, mem_a[ADDR_W-1:18], tx_full, rx_count};

  assign is_io    = (mem_a[17:16] == IO_BASE_SEL);
  assign io_sel   = mem_a[2:0];
  assign ram_addr = mem_a[RAM_ADDR_BITS-1:0];
  assign bus_wr   = rdy_in && mem_wr;
  assign bus_rd   = rdy_in && !mem_wr;
  assign ram_we   = bus_wr && !is_io;

  // The stop write pushes a 0x00 terminator, which the UART zero filter would otherwise drop.
  assign uart_wr      = bus_wr && is_io && (io_sel == IO_UART_ADDR) && (mem_dout != '0);
  assign stop_wr      = bus_wr && is_io && (io_sel == IO_CLK_ADDR);
  assign tx_push      = uart_wr || stop_wr;
  assign tx_push_data = stop_wr ? '0 : mem_dout;
  assign tx_pop       = tx_valid && tx_ready;
  assign tx_valid     = !tx_empty;

  // One slot of margin absorbs a CPU write already in flight when the flag rises.
  assign io_buffer_full = (tx_count >= TX_CW'(TX_DEPTH - 1));

  assign rx_ready = !rx_full;
  assign rx_push  = rx_valid && rx_ready;
  assign rx_pop   = bus_rd && is_io && (io_sel == IO_UART_ADDR);

  byte_fifo #(.DEPTH_BITS(TX_DEPTH_BITS)) u_tx_fifo (
    .clk_in(clk_in), .rst_in(rst_in), .push(tx_push), .push_data(tx_push_data),
    .pop(tx_pop), .pop_data(tx_data), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  byte_fifo #(.DEPTH_BITS(RX_DEPTH_BITS)) u_rx_fifo (
    .clk_in(clk_in), .rst_in(rst_in), .push(rx_push), .push_data(rx_data),
    .pop(rx_pop), .pop_data(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  // I/O read data; reading the low counter byte returns the live count that becomes the snapshot.
  always_comb begin
    io_rd_data = '0;
    if (io_sel == IO_UART_ADDR) begin
      io_rd_data = rx_empty ? '0 : rx_head;
    end else if (io_sel == IO_CLK_ADDR) begin
      io_rd_data = cycle_cnt[DATA_W-1:0];
    end else if (io_sel[2]) begin
      io_rd_data = snapshot[{io_sel[1:0], 3'b000} +: DATA_W];
    end
  end

  always_ff @(posedge clk_in) begin
    if (ram_we) ram[ram_addr] <= mem_dout;
    if (bus_rd) ram_rd_q <= ram[ram_addr];
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sel_ram_q    <= 1'b0;
      io_rd_q      <= '0;
      cycle_cnt    <= '0;
      snapshot     <= '0;
      program_done <= 1'b0;
    end else begin
      if (rdy_in)  cycle_cnt    <= cycle_cnt + 32'd1;
      if (stop_wr) program_done <= 1'b1;
      if (bus_rd) begin
        sel_ram_q <= !is_io;
        io_rd_q   <= is_io ? io_rd_data : '0;
        if (is_io && (io_sel == IO_CLK_ADDR)) snapshot <= cycle_cnt;
      end
    end
  end

  assign mem_din = sel_ram_q ? ram_rd_q : io_rd_q;
endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder with scoreboard queues for bus reads and the TX stream.
module tb_mem_io_responder;
  logic        clk_in;
  logic        rst_in;
  logic        rdy_in;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        program_done;

  int checks = 0;
  int errors = 0;
  logic [7:0] rd_q[$];
  logic [7:0] tx_q[$];

  mem_io_responder dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .mem_a(mem_a),
    .mem_dout(mem_dout), .mem_wr(mem_wr), .mem_din(mem_din),
    .io_buffer_full(io_buffer_full), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .program_done(program_done)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Any byte the UART takes on the coming edge is scored against the TX queue.
  task automatic step();
    if (tx_valid && tx_ready) begin
      if (tx_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL tx_extra observed=0x%0h expected=none", tx_data);
      end else begin
        check("tx_byte", 32'(tx_data), 32'(tx_q.pop_front()));
      end
    end
    @(posedge clk_in);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [7:0] d);
    mem_a = a; mem_dout = d; mem_wr = 1'b1;
    step();
    mem_a = 32'h0; mem_wr = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, input logic [7:0] e, input string tag);
    rd_q.push_back(e);
    mem_a = a; mem_wr = 1'b0;
    step();
    check(tag, 32'(mem_din), 32'(rd_q.pop_front()));
    mem_a = 32'h0;
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; mem_a = 32'h0; mem_dout = 8'h0; mem_wr = 1'b0;
    tx_ready = 1'b0; rx_data = 8'h0; rx_valid = 1'b0;
    step(); step();
    check("rst_mem_din", 32'(mem_din), 32'h0);
    check("rst_tx_valid", 32'(tx_valid), 32'h0);
    check("rst_buf_full", 32'(io_buffer_full), 32'h0);
    check("rst_done", 32'(program_done), 32'h0);
    check("rst_rx_ready", 32'(rx_ready), 32'h1);

    // 100 enabled cycles with 20 stalled ones interleaved
    rst_in = 1'b0;
    for (int i = 0; i < 120; i++) begin
      rdy_in = (i % 6) != 5;
      step();
    end
    rdy_in = 1'b1;
    bus_read(32'h30004, 8'h64, "clk_b0");
    bus_read(32'h30005, 8'h00, "clk_b1");
    bus_read(32'h30006, 8'h00, "clk_b2");
    bus_read(32'h30007, 8'h00, "clk_b3");

    bus_write(32'h00010, 8'hA5);
    bus_read(32'h00010, 8'hA5, "ram_rd");
    bus_write(32'h1FFFF, 8'h5A);
    bus_read(32'h00010, 8'hA5, "ram_b2b0");
    bus_read(32'h1FFFF, 8'h5A, "ram_b2b1");
    bus_write(32'h20010, 8'h77);
    bus_read(32'h00010, 8'h77, "ram_alias");

    // Stalled bus: no RAM write, no TX push, mem_din held
    rdy_in = 1'b0;
    mem_a = 32'h10; mem_dout = 8'hEE; mem_wr = 1'b1;
    step();
    check("stall_hold", 32'(mem_din), 32'h77);
    mem_a = 32'h30000; mem_dout = 8'h55;
    step();
    check("stall_no_tx", 32'(tx_valid), 32'h0);
    mem_wr = 1'b0; rdy_in = 1'b1;
    bus_read(32'h00010, 8'h77, "stall_no_wr");

    // Zero byte is filtered from the UART stream
    tx_ready = 1'b1;
    tx_q.push_back(8'h48); bus_write(32'h30000, 8'h48);
    bus_write(32'h30000, 8'h00);
    tx_q.push_back(8'h69); bus_write(32'h30000, 8'h69);
    repeat (5) step();
    check("tx_stream_done", 32'(tx_q.size()), 32'h0);

    tx_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tx_q.push_back(8'(8'h41 + i));
      bus_write(32'h30000, 8'(8'h41 + i));
      if (i == 13) check("buf_full_14", 32'(io_buffer_full), 32'h0);
    end
    check("buf_full_15", 32'(io_buffer_full), 32'h1);
    tx_q.push_back(8'h50); bus_write(32'h30000, 8'h50);
    bus_write(32'h30000, 8'h99);
    tx_ready = 1'b1;
    repeat (20) step();
    check("drain_count", 32'(tx_q.size()), 32'h0);
    check("drain_empty", 32'(tx_valid), 32'h0);

    rx_valid = 1'b1; rx_data = 8'h31;
    step();
    rx_data = 8'h32;
    step();
    rx_valid = 1'b0;
    check("rx_ready", 32'(rx_ready), 32'h1);
    bus_read(32'h30000, 8'h31, "rx_pop0");
    bus_read(32'h30000, 8'h32, "rx_pop1");
    bus_read(32'h30000, 8'h00, "rx_empty");
    bus_read(32'h30002, 8'h00, "io_other");

    tx_ready = 1'b0;
    bus_write(32'h30004, 8'hFF);
    bus_read(32'h00010, 8'h77, "pre_rst_rd");
    check("done_set", 32'(program_done), 32'h1);
    check("term_valid", 32'(tx_valid), 32'h1);
    check("term_byte", 32'(tx_data), 32'h0);

    rst_in = 1'b1;
    step();
    check("rst2_done", 32'(program_done), 32'h0);
    check("rst2_tx_valid", 32'(tx_valid), 32'h0);
    check("rst2_mem_din", 32'(mem_din), 32'h0);
    check("rst2_buf_full", 32'(io_buffer_full), 32'h0);
    rst_in = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
